// File: rtl/ram_pkg.sv
// Shared definitions for the two-requester RAM arbiter:
// operation encodings and the access state machine states.
package ram_pkg;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      FINISH = 2'd3
   } state_t;

endpackage

// File: rtl/ram_rr_pick.sv
// Two-way round-robin pick: a lone request wins, and when both
// requesters are asking the one not granted last time wins.
module ram_rr_pick (
   input  logic [1:0] req,
   input  logic       last,
   output logic       valid,
   output logic       index
);

   always_comb begin
      valid = |req;
      index = 1'b0;
      unique case (req)
         2'b01:   index = 1'b0;
         2'b10:   index = 1'b1;
         2'b11:   index = ~last;
         default: index = 1'b0;
      endcase
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between two requesters. Each access
// takes a setup cycle, a one-cycle select strobe and a finish cycle.
module ram_arbiter
   import ram_pkg::*;
#(
   parameter int WORD_SIZE   = 20,
   parameter int WORD_AMOUNT = 30,
   localparam int AW         = $clog2(WORD_AMOUNT)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           req,
   input  logic [1:0]           op,
   input  logic [AW-1:0]        addr0,
   input  logic [AW-1:0]        addr1,
   input  logic [WORD_SIZE-1:0] wdata0,
   input  logic [WORD_SIZE-1:0] wdata1,
   output logic [1:0]           ack,
   output logic [1:0]           err,
   output logic [WORD_SIZE-1:0] rdata,
   output logic                 ram_select,
   output logic                 ram_operation,
   output logic [AW-1:0]        ram_address,
   output logic [WORD_SIZE-1:0] ram_wdata,
   input  logic [WORD_SIZE-1:0] ram_rdata
);

   localparam logic [AW:0] LIMIT = (AW+1)'(WORD_AMOUNT);

   state_t               state;
   state_t               state_n;
   logic [1:0]           sync;
   logic                 grant;
   logic                 l_op;
   logic                 l_bad;
   logic [AW-1:0]        l_addr;
   logic [WORD_SIZE-1:0] l_wdata;
   logic                 pick_valid;
   logic                 pick_idx;
   logic                 s_op;
   logic                 s_bad;
   logic [AW-1:0]        s_addr;
   logic [WORD_SIZE-1:0] s_wdata;
   logic                 take;
   logic                 cap;

   ram_rr_pick u_pick (
      .req   (req),
      .last  (grant),
      .valid (pick_valid),
      .index (pick_idx)
   );

   // Arbitration is held off until reset release has passed the
   // two-stage synchroniser.
   always_comb begin
      s_op       = op[pick_idx];
      s_addr     = pick_idx ? addr1 : addr0;
      s_wdata    = pick_idx ? wdata1 : wdata0;
      s_bad      = {1'b0, s_addr} >= LIMIT;
      state_n    = state;
      take       = 1'b0;
      cap        = 1'b0;
      ram_select = 1'b0;
      ack        = 2'b00;
      err        = 2'b00;
      unique case (state)
         IDLE: begin
            if (sync[1] && pick_valid) begin
               take    = 1'b1;
               state_n = s_bad ? FINISH : SETUP;
            end
         end
         SETUP: state_n = STROBE;
         STROBE: begin
            state_n    = FINISH;
            ram_select = 1'b1;
            cap        = (l_op == OP_READ);
         end
         FINISH: begin
            state_n    = IDLE;
            ack[grant] = 1'b1;
            err[grant] = l_bad;
         end
      endcase
   end

   assign ram_operation = l_op;
   assign ram_address   = l_addr;
   assign ram_wdata     = l_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         sync    <= 2'b00;
         grant   <= 1'b1;
         l_op    <= OP_READ;
         l_bad   <= 1'b0;
         l_addr  <= '0;
         l_wdata <= '0;
         rdata   <= '0;
      end else begin
         sync  <= {sync[0], 1'b1};
         state <= state_n;
         if (take) begin
            grant   <= pick_idx;
            l_op    <= s_op;
            l_bad   <= s_bad;
            l_addr  <= s_addr;
            l_wdata <= s_wdata;
         end
         // Captured at the end of the strobe so it is valid with ack.
         if (cap)
            rdata <= ram_rdata;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random accesses
// checked against a transaction-level arbiter and memory model.
module tb_ram_arbiter;

   localparam int WS = 20;
   localparam int WA = 30;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    req;
   logic [1:0]    op;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [WS-1:0] wdata0;
   logic [WS-1:0] wdata1;
   logic [1:0]    ack;
   logic [1:0]    err;
   logic [WS-1:0] rdata;
   logic          ram_select;
   logic          ram_operation;
   logic [AW-1:0] ram_address;
   logic [WS-1:0] ram_wdata;
   logic [WS-1:0] ram_rdata = '0;

   always #5 clk = ~clk;

   ram_arbiter #(.WORD_SIZE(WS), .WORD_AMOUNT(WA)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req           (req),
      .op            (op),
      .addr0         (addr0),
      .addr1         (addr1),
      .wdata0        (wdata0),
      .wdata1        (wdata1),
      .ack           (ack),
      .err           (err),
      .rdata         (rdata),
      .ram_select    (ram_select),
      .ram_operation (ram_operation),
      .ram_address   (ram_address),
      .ram_wdata     (ram_wdata),
      .ram_rdata     (ram_rdata)
   );

   // RAM device: acts on the rising edge of select.
   logic [WS-1:0] mem [32] = '{default: '0};
   int            sel_cnt = 0;
   logic [AW-1:0] sel_addr = '0;
   logic          sel_op = 1'b0;
   logic [WS-1:0] sel_wdata = '0;

   always @(posedge ram_select) begin
      sel_cnt   = sel_cnt + 1;
      sel_addr  = ram_address;
      sel_op    = ram_operation;
      sel_wdata = ram_wdata;
      if (ram_operation)
         mem[ram_address] = ram_wdata;
      else
         ram_rdata = mem[ram_address];
   end

   bit stab_err = 1'b0;
   bit hot_err  = 1'b0;

   always @(ram_address or ram_operation)
      if (ram_select === 1'b1 && rst_n === 1'b1)
         stab_err = 1'b1;

   always @(negedge clk)
      if (rst_n === 1'b1 && !$onehot0(ack))
         hot_err = 1'b1;

   int            total = 0;
   int            bad   = 0;
   int            m_last = 1;
   logic [WS-1:0] ref_mem [32] = '{default: '0};
   logic [WS-1:0] m_rdata = '0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One access from an idle arbiter; called at a falling edge.
   task automatic xact(input logic [1:0] r, input logic [1:0] o,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [WS-1:0] d0, input logic [WS-1:0] d1,
                       input bit scramble, input string tag);
      int            w;
      int            n;
      int            sc0;
      bit            oor;
      logic          oo;
      logic [AW-1:0] a;
      logic [WS-1:0] d;
      if (r == 2'b11) w = (m_last == 1) ? 0 : 1;
      else            w = r[1] ? 1 : 0;
      m_last = w;
      a   = (w == 1) ? a1 : a0;
      d   = (w == 1) ? d1 : d0;
      oo  = o[w];
      oor = (int'(a) >= WA);
      sc0 = sel_cnt;
      req = r; op = o; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (scramble && n == 1 && ack === 2'b00) begin
            op     = 2'($urandom);
            addr0  = AW'($urandom);
            addr1  = AW'($urandom);
            wdata0 = WS'($urandom);
            wdata1 = WS'($urandom);
         end
      end while (ack === 2'b00 && n < 12);
      if (!oor) begin
         if (oo) ref_mem[a] = d;
         else    m_rdata = ref_mem[a];
      end
      chk($sformatf("%s latency", tag), n, oor ? 1 : 3);
      chk($sformatf("%s ack", tag), ack, 1 << w);
      chk($sformatf("%s err", tag), err, oor ? (1 << w) : 0);
      chk($sformatf("%s rdata", tag), rdata, m_rdata);
      chk($sformatf("%s strobes", tag), sel_cnt - sc0, oor ? 0 : 1);
      if (!oor) begin
         chk($sformatf("%s ram addr", tag), sel_addr, a);
         chk($sformatf("%s ram op", tag), sel_op, oo);
         if (oo)
            chk($sformatf("%s ram wdata", tag), sel_wdata, d);
      end
      req = 2'b00;
      @(negedge clk);
   endtask

   int n;
   int w;

   initial begin
      rst_n = 1'b0;
      req = '0; op = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      repeat (2) @(negedge clk);
      chk("reset select", ram_select, 0);
      chk("reset ack", ack, 0);
      chk("reset err", err, 0);
      chk("reset rdata", rdata, 0);
      chk("reset address", ram_address, 0);
      chk("reset operation", ram_operation, 0);
      chk("reset wdata", ram_wdata, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Both requesters held high: strict alternation from 0.
      req = 2'b11; op = 2'b01; addr0 = 5'd3; addr1 = 5'd3;
      wdata0 = 20'hABCDE; wdata1 = 20'h0;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (ack === 2'b00 && n < 12);
         w = (m_last == 1) ? 0 : 1;
         m_last = w;
         if (w == 0) ref_mem[3] = 20'hABCDE;
         else        m_rdata = ref_mem[3];
         chk($sformatf("alt%0d gap", i), n, (i == 0) ? 3 : 4);
         chk($sformatf("alt%0d ack", i), ack, 1 << w);
         chk($sformatf("alt%0d err", i), err, 0);
         chk($sformatf("alt%0d rdata", i), rdata, m_rdata);
      end
      req = 2'b00;
      @(negedge clk);

      xact(2'b01, 2'b01, 5'd5, 5'd0, 20'h12345, 20'h0, 1'b0, "wr5");
      xact(2'b10, 2'b00, 5'd0, 5'd5, 20'h0, 20'h0, 1'b0, "rd5");
      chk("rd5 value", rdata, 20'h12345);
      xact(2'b01, 2'b00, 5'd31, 5'd0, 20'h0, 20'h0, 1'b0, "oor31");
      xact(2'b10, 2'b10, 5'd0, 5'd30, 20'h0, 20'h55555, 1'b0, "oor30");

      // Reset in the strobe cycle aborts the access.
      req = 2'b01; op = 2'b00; addr0 = 5'd5;
      @(negedge clk);
      @(negedge clk);
      chk("abort strobe seen", ram_select, 1);
      rst_n = 1'b0;
      #1;
      chk("abort select drop", ram_select, 0);
      chk("abort no ack", ack, 0);
      chk("abort rdata clear", rdata, 0);
      m_last = 1;
      m_rdata = '0;
      @(negedge clk);
      chk("abort ack in reset", ack, 0);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ack === 2'b00 && n < 12);
      m_last = 0;
      m_rdata = ref_mem[5];
      chk("retry latency window", (n >= 4 && n < 12) ? 1 : 0, 1);
      chk("retry ack", ack, 2'b01);
      chk("retry err", err, 0);
      chk("retry rdata", rdata, m_rdata);
      req = 2'b00;
      @(negedge clk);

      for (int i = 0; i < 40; i++)
         xact(2'($urandom_range(1, 3)), 2'($urandom),
              AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
              WS'($urandom), WS'($urandom), 1'b1,
              $sformatf("rnd%0d", i));

      chk("ram stable under select", stab_err, 0);
      chk("ack one-hot", hot_err, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 20, RAM data width in bits.
REQ-002 SHALL have parameter WORD_AMOUNT, default 30, number of RAM words; AW = $clog2(WORD_AMOUNT).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  2  per-requester access request, bit i = requester i.
REQ-006 SHALL have port op  input  2  per-requester operation, READ=0, WRITE=1.
REQ-007 SHALL have port addr0 / addr1  input  AW each  per-requester word address.
REQ-008 SHALL have port wdata0 / wdata1  input  WORD_SIZE each  per-requester write data.
REQ-009 SHALL have port ack  output  2  one-cycle completion pulse per requester.
REQ-010 SHALL have port err  output  2  one-cycle pulse with ack, address out of range.
REQ-011 SHALL have port rdata  output  WORD_SIZE  read result, valid in ack cycle, held until next read completes.
REQ-012 SHALL have ports ram_select, ram_operation (output, 1 each), ram_address (output, AW), ram_wdata (output, WORD_SIZE), ram_rdata (input, WORD_SIZE) to the single-port RAM, which acts on rising edge of select.

Function
REQ-013 SHALL implement FSM IDLE -> SETUP -> STROBE -> FINISH -> IDLE.
REQ-014 IDLE: if any req bit high, SHALL latch grant, op, addr, wdata of the winner and go SETUP; else stay.
REQ-015 Arbitration SHALL be round-robin: single request wins; both high -> requester not granted last wins; after reset requester 0 has priority.
REQ-016 SETUP: SHALL drive ram_address/ram_operation/ram_wdata from latched values with ram_select=0 (one cycle setup before strobe).
REQ-017 STROBE: SHALL hold ram_* stable and assert ram_select=1 for exactly one cycle.
REQ-018 FINISH: ram_select=0; SHALL pulse ack[grant]; for READ SHALL register ram_rdata into rdata in this cycle.
REQ-019 Latency SHALL be 3 cycles from IDLE accepting req to ack pulse; throughput one access per 4 cycles.
REQ-020 Requester SHALL hold req/op/addr/wdata until ack; arbiter ignores input changes after latch.
REQ-021 req still high in cycle after ack SHALL be treated as a new request (IDLE re-arbitrates).
REQ-022 Latched addr >= WORD_AMOUNT: SHALL skip SETUP/STROBE (no ram_select pulse), go FINISH, pulse ack and err; rdata unchanged.
REQ-023 Requests arriving outside IDLE SHALL wait; none dropped while req held.
REQ-024 ram_operation and ram_address SHALL never change while ram_select=1.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, ram_select=0, ack=0, err=0, rdata=0, ram_address=0, ram_operation=READ, ram_wdata=0, last-grant pointer = requester 1 (so 0 wins first).
REQ-026 Reset mid-access SHALL abort it with no ack; requester re-issues after reset.
REQ-027 Reset release SHALL be synchronised for state-change purposes; first arbitration at earliest on second rising edge after rst_n rises.

Structure
REQ-028 Shared package ram_pkg SHALL hold READ/WRITE constants and the FSM state enum.
REQ-029 Round-robin choice SHALL be sub-module ram_rr_pick (inputs req, last; outputs grant valid/index), combinational.
REQ-030 Implementation SHALL be one always_ff (async reset) for state/latches, one always_comb for next-state/outputs.

Verification
REQ-031 Req0 WRITE addr 5 data 0x12345 -> ram_select single pulse with addr 5, op WRITE; ack[0] 3 cycles after acceptance.
REQ-032 Then req1 READ addr 5 -> rdata=0x12345 in ack[1] cycle, err=0.
REQ-033 req=2'b11 held continuously after reset -> grants alternate 0,1,0,1; each ack 4 cycles apart.
REQ-034 Req0 READ addr 31 (WORD_AMOUNT=30) -> ack[0] and err[0] together, no ram_select pulse, rdata unchanged.
REQ-035 rst_n low during STROBE -> ram_select low same cycle, no ack; after release req0 repeats and completes normally.
REQ-036 Assertion over all tests: ram_address/ram_operation stable whenever ram_select=1; ack one-hot or zero.
